ram2_ctrl: RTL

RAM2_CTRL -- requirements
Module: ram2_ctrl

---
 rtl/ram2_ctrl.sv | 107 ++++++++++
 1 files changed

// File: rtl/ram2_ctrl.sv
// ============================================================================
// Module   : ram2_ctrl
// Brief    : Request/response controller for a single-port RAM with a shared
//            bidirectional data bus. Writes take WR+TURN, reads take RD+RD_CAP.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ram2_ctrl #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic              rsp_we,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              busy,
  output logic              ram_ena,
  output logic              ram_wena,
  output logic [ADDR_W-1:0] ram_addr,
  inout  wire  [DATA_W-1:0] ram_data_io
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_WR     = 3'd1;
  localparam logic [2:0] S_TURN   = 3'd2;
  localparam logic [2:0] S_RD     = 3'd3;
  localparam logic [2:0] S_RD_CAP = 3'd4;

  logic [2:0]        state_q;
  logic [2:0]        state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              rsp_valid_q;
  logic              rsp_we_q;
  logic [DATA_W-1:0] rsp_rdata_q;
  logic              accept;

  assign accept = req_valid && (state_q == S_IDLE);

  // Next-state selection: IDLE branches on request type, every other state is one cycle long.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (accept) state_d = req_we ? S_WR : S_RD;
      S_WR:     state_d = S_TURN;
      S_TURN:   state_d = S_IDLE;
      S_RD:     state_d = S_RD_CAP;
      S_RD_CAP: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // State register and request latch; address/data only change on acceptance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
      end
    end
  end

  // Response pulse one cycle after the last RAM-access state; read data is captured off the bus.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_q <= 1'b0;
      rsp_we_q    <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      rsp_valid_q <= (state_q == S_WR) || (state_q == S_RD_CAP);
      if (state_q == S_WR) begin
        rsp_we_q <= 1'b1;
      end else if (state_q == S_RD_CAP) begin
        rsp_we_q    <= 1'b0;
        rsp_rdata_q <= ram_data_io;
      end
    end
  end

  assign req_ready = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign ram_ena   = (state_q == S_WR) || (state_q == S_RD) || (state_q == S_RD_CAP);
  assign ram_wena  = (state_q == S_WR);
  assign ram_addr  = addr_q;

  // The controller owns the bus only while writing, so it can never fight the RAM's read drive.
  assign ram_data_io = (state_q == S_WR) ? wdata_q : {DATA_W{1'bz}};

  assign rsp_valid = rsp_valid_q;
  assign rsp_we    = rsp_we_q;
  assign rsp_rdata = rsp_rdata_q;

endmodule

`default_nettype wire
